// File: rtl/dfifo.sv
// First-word-fall-through FIFO with valid/ready on both sides, registered storage, no din->dout bypass.
// Optional occupancy output `o_level` is built only when DFIFO_LEVEL_EN is defined.
module dfifo #(
  parameter int DEPTH = 4,
  parameter int W_DIN = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [W_DIN-1:0]         i_din_data,
  input  logic                     i_din_valid,
  output logic                     o_din_ready,
  output logic [W_DIN-1:0]         o_dout_data,
  output logic                     o_dout_valid,
  input  logic                     i_dout_ready
`ifdef DFIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0]   o_level
`endif
);

  // Handshake: a word moves on a rising edge where valid && ready are both high;
  // a producer holds valid and data stable until that edge, and ready never
  // depends combinationally on the partner's valid (or vice versa).

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W_DIN-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;

  logic w_empty;
  logic w_full;
  logic w_wr_en;
  logic w_rd_en;

  // MSB is the wrap flag: equal low bits with differing wrap means full.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);

  assign o_din_ready  = !w_full && !rst;
  assign o_dout_valid = !w_empty && !rst;
  assign o_dout_data  = r_mem[r_rd_ptr[AW-1:0]];

  assign w_wr_en = i_din_valid && o_din_ready;
  assign w_rd_en = o_dout_valid && i_dout_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Storage is not cleared on reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_din_data;
  end

`ifdef DFIFO_LEVEL_EN
  assign o_level = r_wr_ptr - r_rd_ptr;
`endif

endmodule
